// File: rtl/nn_seq_pkg.sv
// Shared types and constants for the two-layer forward-pass sequencer.
package nn_seq_pkg;

    localparam int unsigned DATA_W          = 8;
    localparam int unsigned FRAC_BITS       = 4;
    localparam int unsigned TIMEOUT_DEFAULT = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR0,
        ST_RUN0,
        ST_CLR1,
        ST_RUN1,
        ST_DONE
    } state_t;

    // Bits needed to hold values 0..n, never less than one bit.
    function automatic int unsigned width_for(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/nn_seq_port.sv
// Per-layer port: input-read mux with range check, bad-address detect and
// a saturating RUN-state watchdog.
module nn_seq_port #(
    parameter int unsigned WORD_W  = 8,
    parameter int unsigned N_WORDS = 2,
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_WORDS*WORD_W-1:0]   buf_data,
    input  logic                        trig,
    input  logic [ADDR_W-1:0]           addr,
    input  logic                        wd_clr,
    input  logic                        wd_run,
    output logic [WORD_W-1:0]           rd_data_c,
    output logic                        bad_addr_c,
    output logic                        timeout_c
);
    import nn_seq_pkg::*;

    localparam int unsigned CNT_W = width_for(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wd_cnt;

    // Read mux; addresses past the buffer return zero.
    always_comb begin
        rd_data_c = '0;
        for (int unsigned i = 0; i < N_WORDS; i++) begin
            if (addr == ADDR_W'(i)) begin
                rd_data_c = buf_data[i*WORD_W +: WORD_W];
            end
        end
    end

    // A strobe with an address outside the buffer is an error.
    always_comb begin
        bad_addr_c = trig && (32'(addr) >= N_WORDS);
        timeout_c  = wd_run && (wd_cnt == WD_LAST);
    end

    // Watchdog counts RUN cycles and holds at its last value.
    always_ff @(posedge clk) begin
        if (rst || wd_clr) begin
            wd_cnt <= '0;
        end else if (wd_run && (wd_cnt != WD_LAST)) begin
            wd_cnt <= wd_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Runs one forward pass: latch input, run layer 0, run layer 1, return result.
module nn_layer_sequencer #(
    parameter int unsigned DATA_W  = nn_seq_pkg::DATA_W,
    parameter int unsigned N_IN    = 2,
    parameter int unsigned N_HID   = 2,
    parameter int unsigned N_OUT   = 1,
    parameter int unsigned TIMEOUT = nn_seq_pkg::TIMEOUT_DEFAULT,
    localparam int unsigned A0_W   = nn_seq_pkg::width_for(N_IN),
    localparam int unsigned A1_W   = nn_seq_pkg::width_for(N_HID)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [N_IN*DATA_W-1:0]    x_in,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [N_OUT*DATA_W-1:0]   y_out,
    output logic                      l0_rst,
    output logic                      l0_req,
    input  logic                      l0_trig,
    input  logic [A0_W-1:0]           l0_addr,
    output logic [DATA_W-1:0]         l0_data,
    input  logic                      l0_ack,
    input  logic [N_HID*DATA_W-1:0]   l0_a,
    output logic                      l1_rst,
    output logic                      l1_req,
    input  logic                      l1_trig,
    input  logic [A1_W-1:0]           l1_addr,
    output logic [DATA_W-1:0]         l1_data,
    input  logic                      l1_ack,
    input  logic [N_OUT*DATA_W-1:0]   l1_a
);
    import nn_seq_pkg::*;

    state_t                     state;
    logic [N_IN*DATA_W-1:0]     x_buf;
    logic [N_HID*DATA_W-1:0]    h_buf;
    logic                       bad0_c;
    logic                       bad1_c;
    logic                       to0_c;
    logic                       to1_c;

    // Layer resets follow the global reset and pulse in each layer's CLR cycle.
    assign l0_rst = rst | (state == ST_CLR0);
    assign l1_rst = rst | (state == ST_CLR1);

    nn_seq_port #(
        .WORD_W  (DATA_W),
        .N_WORDS (N_IN),
        .ADDR_W  (A0_W),
        .TIMEOUT (TIMEOUT)
    ) u_port0 (
        .clk        (clk),
        .rst        (rst),
        .buf_data   (x_buf),
        .trig       (l0_trig),
        .addr       (l0_addr),
        .wd_clr     (state == ST_CLR0),
        .wd_run     (state == ST_RUN0),
        .rd_data_c  (l0_data),
        .bad_addr_c (bad0_c),
        .timeout_c  (to0_c)
    );

    nn_seq_port #(
        .WORD_W  (DATA_W),
        .N_WORDS (N_HID),
        .ADDR_W  (A1_W),
        .TIMEOUT (TIMEOUT)
    ) u_port1 (
        .clk        (clk),
        .rst        (rst),
        .buf_data   (h_buf),
        .trig       (l1_trig),
        .addr       (l1_addr),
        .wd_clr     (state == ST_CLR1),
        .wd_run     (state == ST_RUN1),
        .rd_data_c  (l1_data),
        .bad_addr_c (bad1_c),
        .timeout_c  (to1_c)
    );

    // Pass sequencing FSM; ack takes priority over a same-edge timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            l0_req <= 1'b0;
            l1_req <= 1'b0;
            y_out  <= '0;
            x_buf  <= '0;
            h_buf  <= '0;
        end else begin
            done <= 1'b0;
            if ((state != ST_IDLE) && (bad0_c || bad1_c)) begin
                err <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        x_buf <= x_in;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                        state <= ST_CLR0;
                    end
                end
                ST_CLR0: begin
                    l0_req <= 1'b1;
                    state  <= ST_RUN0;
                end
                ST_RUN0: begin
                    if (l0_ack) begin
                        h_buf  <= l0_a;
                        l0_req <= 1'b0;
                        state  <= ST_CLR1;
                    end else if (to0_c) begin
                        err    <= 1'b1;
                        y_out  <= '0;
                        l0_req <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_CLR1: begin
                    l1_req <= 1'b1;
                    state  <= ST_RUN1;
                end
                ST_RUN1: begin
                    if (l1_ack) begin
                        y_out  <= l1_a;
                        l1_req <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end else if (to1_c) begin
                        err    <= 1'b1;
                        y_out  <= '0;
                        l1_req <= 1'b0;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy   <= 1'b0;
                    l0_req <= 1'b0;
                    l1_req <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer with stub layers and a pass-level reference model.
module tb_nn_layer_sequencer;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] x_in;
    logic        busy, done, err;
    logic [7:0]  y_out;
    logic        l0_rst, l0_req, l0_trig, l0_ack;
    logic [1:0]  l0_addr;
    logic [7:0]  l0_data;
    logic [15:0] l0_a;
    logic        l1_rst, l1_req, l1_trig, l1_ack;
    logic [1:0]  l1_addr;
    logic [7:0]  l1_data;
    logic [7:0]  l1_a;

    int n_cmp = 0;
    int n_err = 0;

    // stub layer state and controls
    int         ack0_at = 4;
    int         ack1_at = 3;
    bit         bad0 = 1'b0;
    int         c0 = 0;
    int         c1 = 0;
    logic [7:0] r0 [2] = '{default: 8'h00};
    logic [7:0] r1 [2] = '{default: 8'h00};
    logic [7:0] bad_seen = 8'hFF;

    // event recorders
    int cyc = 0;
    int done_cnt = 0, rp0 = 0, rp1 = 0;
    int req0_cyc = 0, run1_cyc = 0, done_cyc = 0, start_cyc = 0;
    bit req0_prev = 1'b0, req1_prev = 1'b0;

    always #5 clk = ~clk;

    nn_layer_sequencer #(
        .DATA_W (8), .N_IN (2), .N_HID (2), .N_OUT (1), .TIMEOUT (TO)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .x_in (x_in),
        .busy (busy), .done (done), .err (err), .y_out (y_out),
        .l0_rst (l0_rst), .l0_req (l0_req), .l0_trig (l0_trig), .l0_addr (l0_addr),
        .l0_data (l0_data), .l0_ack (l0_ack), .l0_a (l0_a),
        .l1_rst (l1_rst), .l1_req (l1_req), .l1_trig (l1_trig), .l1_addr (l1_addr),
        .l1_data (l1_data), .l1_ack (l1_ack), .l1_a (l1_a)
    );

    // Layer 0 stub: reads x0, x1 (and addr 2 in bad mode), acks at count ack0_at.
    assign l0_trig = l0_req && !l0_ack && ((c0 < 2) || (bad0 && c0 == 2));
    assign l0_addr = 2'(c0);
    assign l0_a    = {8'(r0[0] + r0[1] + 8'd1), 8'(r0[0] + r0[1])};
    always @(posedge clk) begin
        if (l0_rst) begin
            c0 <= 0; l0_ack <= 1'b0;
        end else if (l0_req && !l0_ack) begin
            if (l0_trig) begin
                if (l0_addr < 2'd2) r0[l0_addr[0]] <= l0_data;
                else bad_seen <= l0_data;
            end
            c0 <= c0 + 1;
            if (c0 == ack0_at - 1) l0_ack <= 1'b1;
        end
    end

    // Layer 1 stub: reads h0, h1 and returns their sum at count ack1_at.
    assign l1_trig = l1_req && !l1_ack && (c1 < 2);
    assign l1_addr = 2'(c1);
    assign l1_a    = 8'(r1[0] + r1[1]);
    always @(posedge clk) begin
        if (l1_rst) begin
            c1 <= 0; l1_ack <= 1'b0;
        end else if (l1_req && !l1_ack) begin
            if (l1_trig) r1[l1_addr[0]] <= l1_data;
            c1 <= c1 + 1;
            if (c1 == ack1_at - 1) l1_ack <= 1'b1;
        end
    end

    // Cycle counter and event timestamps, sampled mid-cycle.
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (l0_rst && !rst) rp0++;
        if (l1_rst && !rst) rp1++;
        if (l0_req && !req0_prev) req0_cyc = cyc;
        if (l1_req && !req1_prev) run1_cyc = cyc;
        req0_prev = l0_req;
        req1_prev = l1_req;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: layer 0 gives h_j = x0+x1+j, layer 1 gives h0+h1, all mod 256.
    function automatic logic [7:0] ref_y(input logic [7:0] x0, input logic [7:0] x1);
        int s;
        s = (int'(x0) + int'(x1)) % 256;
        return 8'((s + (s + 1) % 256) % 256);
    endfunction

    task automatic do_pass(input logic [7:0] x0, input logic [7:0] x1, input int a0,
                           input int a1, input bit poke, input bit stuck1, input bit exp_err);
        int  edges;
        bit  busy_ok;
        int  d0, p0, p1;
        ack0_at = a0;
        ack1_at = a1;
        d0 = done_cnt; p0 = rp0; p1 = rp1;
        @(negedge clk);
        x_in = {x1, x0}; start = 1'b1;
        @(negedge clk);
        start = 1'b0; x_in = 16'($urandom); start_cyc = cyc; busy_ok = busy;
        chk("err_clear_on_start", err, 0);
        edges = 0;
        while (!done && edges < 200) begin
            @(negedge clk);
            edges++;
            busy_ok = busy_ok & busy;
            if (poke && edges == 3) begin start = 1'b1; x_in = 16'($urandom); end
            else start = 1'b0;
        end
        start = 1'b0;
        chk("busy_through_pass", busy_ok, 1);
        repeat (3) @(negedge clk);
        chk("idle_after_pass", busy, 0);
        chk("done_pulses", done_cnt - d0, 1);
        chk("l0_rst_pulses", rp0 - p0, 1);
        chk("l1_rst_pulses", rp1 - p1, 1);
        chk("req0_after_clr0", req0_cyc - start_cyc, 1);
        if (stuck1) begin
            chk("timeout_err", err, 1);
            chk("timeout_y", y_out, 0);
            chk("timeout_latency", done_cyc - run1_cyc, TO);
        end else begin
            chk("y_out", y_out, ref_y(x0, x1));
            chk("pass_latency", edges, a0 + a1 + 4);
            chk("err", err, exp_err);
        end
    endtask

    initial begin
        logic [7:0] rx0, rx1;
        int d0;
        rst = 1'b1; start = 1'b1; x_in = 16'h1234;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_y", y_out, 0);
        chk("rst_req", {l1_req, l0_req}, 0);
        chk("rst_layer_rst", {l1_rst, l0_rst}, 2'b11);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("start_with_rst_ignored", busy, 0);

        do_pass(8'd16, 8'd0, 4, 3, 1'b0, 1'b0, 1'b0);
        chk("basic_y33", y_out, 33);
        do_pass(8'd16, 8'd16, 5, 4, 1'b1, 1'b0, 1'b0);
        chk("b2b_y65", y_out, 65);
        do_pass(8'd0, 8'd0, 4, 6, 1'b0, 1'b0, 1'b0);
        chk("b2b_y1", y_out, 1);

        do_pass(8'd5, 8'd7, 4, 1000, 1'b0, 1'b1, 1'b1);

        bad0 = 1'b1; bad_seen = 8'hFF;
        do_pass(8'd3, 8'd4, 5, 3, 1'b0, 1'b0, 1'b1);
        chk("bad_addr_data", bad_seen, 0);
        bad0 = 1'b0;

        do_pass(8'd9, 8'd2, 15, 3, 1'b0, 1'b0, 1'b0);

        // reset during RUN0 after a bad-address strobe has set err
        bad0 = 1'b1; ack0_at = 10; d0 = done_cnt;
        @(negedge clk); x_in = {8'd1, 8'd2}; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_err_set", err, 1);
        chk("mid_in_run0", l0_req, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_idle", busy, 0);
        chk("mid_rst_layers", {l1_rst, l0_rst}, 2'b11);
        chk("mid_rst_y", y_out, 0);
        chk("mid_rst_err", err, 0);
        rst = 1'b0; bad0 = 1'b0;
        repeat (25) @(negedge clk);
        chk("mid_rst_no_done", done_cnt - d0, 0);
        chk("mid_rst_stays_idle", busy, 0);

        for (int i = 0; i < 6; i++) begin
            rx0 = 8'($urandom);
            rx1 = 8'($urandom);
            do_pass(rx0, rx1, 4 + int'($urandom_range(0, 8)),
                    3 + int'($urandom_range(0, 9)), 1'($urandom), 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
